// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: small word FIFO feeding a start/data/parity/stop frame FSM,
// with all bit timing taken from the external 16x baud pulse.
module uart_tx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          baud16,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  par;
  logic                  push;
  logic                  pop;
  logic                  bit_end;
  logic                  last_stop;

  assign tx_ready  = (fifo_count != FULL);
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign push      = tx_valid && tx_ready;
  assign bit_end   = baud16 && (tick_cnt == TICK_LAST);
  assign last_stop = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
  // The FSM is the only consumer: once from IDLE on a tick, or chained off the final stop bit.
  assign pop       = (fifo_count != '0) && (((state == IDLE) && baud16) || last_stop);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Payload storage carries no reset; every word is written before it can be read.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= tx_data;
    if (pop) begin
      shift <= mem[rd_ptr];
      par   <= 1'b0;
    end else if ((state == DATA) && bit_end) begin
      shift <= shift >> 1;
      par   <= par ^ shift[0];
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      if ((state != IDLE) && baud16) tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
      case (state)
        IDLE: begin
          if (pop) begin
            txd      <= 1'b0;
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            txd     <= shift[0];
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              stop_cnt <= 1'b0;
              if (PARITY_EN != 0) begin
                txd   <= par ^ shift[0] ^ ODD;
                state <= PARITY;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              txd     <= shift[1];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            txd      <= 1'b1;
            state    <= STOP;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              if (pop) begin
                txd   <= 1'b0;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: default, even/odd parity and two-stop-bit instances
// driven from one shared clock, reset and baud pulse.
module tb_uart_tx_sequencer;

  logic       sysclk;
  logic       reset;
  logic       baud16;
  logic       baud_en;
  logic [1:0] div;
  logic [7:0] tx_data;
  logic [3:0] vld;
  logic [3:0] txd_s;
  logic [3:0] busy_s;
  logic [3:0] rdy_s;
  logic [2:0] cnt_s [4];
  bit         saw_low;
  int         checks;
  int         failures;

  uart_tx_sequencer u0 (
    .sysclk(sysclk), .reset(reset), .baud16(baud16), .tx_data(tx_data), .tx_valid(vld[0]),
    .tx_ready(rdy_s[0]), .txd(txd_s[0]), .busy(busy_s[0]), .fifo_count(cnt_s[0]));
  uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .sysclk(sysclk), .reset(reset), .baud16(baud16), .tx_data(tx_data), .tx_valid(vld[1]),
    .tx_ready(rdy_s[1]), .txd(txd_s[1]), .busy(busy_s[1]), .fifo_count(cnt_s[1]));
  uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .sysclk(sysclk), .reset(reset), .baud16(baud16), .tx_data(tx_data), .tx_valid(vld[2]),
    .tx_ready(rdy_s[2]), .txd(txd_s[2]), .busy(busy_s[2]), .fifo_count(cnt_s[2]));
  uart_tx_sequencer #(.STOP_BITS(2)) u3 (
    .sysclk(sysclk), .reset(reset), .baud16(baud16), .tx_data(tx_data), .tx_valid(vld[3]),
    .tx_ready(rdy_s[3]), .txd(txd_s[3]), .busy(busy_s[3]), .fifo_count(cnt_s[3]));

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // One-cycle baud16 pulse every 4 sysclk, changed on the falling edge.
  always @(negedge sysclk) begin
    if (!baud_en) begin
      baud16 = 1'b0;
      div    = 2'd0;
    end else begin
      baud16 = (div == 2'd3);
      div    = div + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d);
    tx_data = d;
    vld[k]  = 1'b1;
    tick(1);
    vld[k]  = 1'b0;
  endtask

  // The start bit must appear on exactly the edge that sees the next baud16 pulse.
  task automatic wait_start(input int k, input string tag);
    bit b;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge sysclk);
      b = baud16;
      #1;
      if (b) begin
        done = 1'b1;
        chk({tag, "_start"}, 16'(txd_s[k]), 16'h0);
      end else begin
        chk({tag, "_prestart"}, 16'(txd_s[k]), 16'h1);
      end
    end
    chk({tag, "_started"}, 16'(done), 16'h1);
  endtask

  // bits[i] is the i-th level on the line; each must last exactly 64 sysclk.
  task automatic check_frame(input int k, input logic [15:0] bits, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_b%0d_head", tag, i), 16'(txd_s[k]), 16'(bits[i]));
      tick(63);
      chk($sformatf("%s_b%0d_tail", tag, i), 16'(txd_s[k]), 16'(bits[i]));
      if (i == n - 1) chk({tag, "_busy_last"}, 16'(busy_s[k]), 16'h1);
      tick(1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    baud_en  = 1'b0;
    vld      = 4'b0;
    tx_data  = 8'h00;
    saw_low  = 1'b0;

    #12;
    chk("rst_txd", 16'(txd_s[0]), 16'h1);
    chk("rst_ready", 16'(rdy_s[0]), 16'h1);
    chk("rst_busy", 16'(busy_s[0]), 16'h0);
    chk("rst_count", 16'(cnt_s[0]), 16'h0);
    chk("rst_txd_u3", 16'(txd_s[3]), 16'h1);
    #10 reset = 1'b1;
    tick(1);

    // Single 0x55 frame
    baud_en = 1'b1;
    tick(2);
    push(0, 8'h55);
    chk("t1_count", 16'(cnt_s[0]), 16'h1);
    chk("t1_busy", 16'(busy_s[0]), 16'h1);
    wait_start(0, "t1");
    check_frame(0, {1'b1, 8'h55, 1'b0}, 10, "t1");
    chk("t1_busy_end", 16'(busy_s[0]), 16'h0);
    chk("t1_idle_txd", 16'(txd_s[0]), 16'h1);

    // Back-to-back 0xA5, 0x3C
    baud_en = 1'b0;
    tick(1);
    push(0, 8'hA5);
    chk("t2_count1", 16'(cnt_s[0]), 16'h1);
    push(0, 8'h3C);
    chk("t2_count2", 16'(cnt_s[0]), 16'h2);
    baud_en = 1'b1;
    wait_start(0, "t2");
    chk("t2_count3", 16'(cnt_s[0]), 16'h1);
    check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, "t2a");
    chk("t2_count4", 16'(cnt_s[0]), 16'h0);
    check_frame(0, {1'b1, 8'h3C, 1'b0}, 10, "t2b");
    chk("t2_busy_end", 16'(busy_s[0]), 16'h0);

    // FIFO full with baud16 held low, fifth word refused
    baud_en = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(17 * (i + 1));
      vld[0]  = 1'b1;
      tick(1);
      chk($sformatf("t3_count_%0d", i), 16'(cnt_s[0]), 16'((i < 4) ? i + 1 : 4));
      chk($sformatf("t3_ready_%0d", i), 16'(rdy_s[0]), 16'((i < 3) ? 1 : 0));
    end
    vld[0]  = 1'b0;
    baud_en = 1'b1;
    wait_start(0, "t3");
    for (int f = 0; f < 4; f++) begin
      logic [7:0] d;
      d = 8'(17 * (f + 1));
      check_frame(0, {1'b1, d, 1'b0}, 10, $sformatf("t3f%0d", f));
    end
    chk("t3_busy_end", 16'(busy_s[0]), 16'h0);
    chk("t3_ready_end", 16'(rdy_s[0]), 16'h1);
    chk("t3_count_end", 16'(cnt_s[0]), 16'h0);
    saw_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (txd_s[0] == 1'b0) saw_low = 1'b1;
    end
    chk("t3_no_fifth", 16'(saw_low), 16'h0);

    // Parity: 0x07 has odd weight, so even parity bit is 1 and odd parity bit is 0
    push(1, 8'h07);
    wait_start(1, "t4e");
    check_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "t4e");
    chk("t4e_busy_end", 16'(busy_s[1]), 16'h0);
    push(2, 8'h07);
    wait_start(2, "t4o");
    check_frame(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, "t4o");
    chk("t4o_busy_end", 16'(busy_s[2]), 16'h0);

    // Two stop bits, followed directly by the next frame's start
    baud_en = 1'b0;
    tick(1);
    push(3, 8'hFF);
    push(3, 8'h00);
    baud_en = 1'b1;
    wait_start(3, "t5");
    check_frame(3, {1'b1, 1'b1, 8'hFF, 1'b0}, 11, "t5a");
    check_frame(3, {1'b1, 1'b1, 8'h00, 1'b0}, 11, "t5b");
    chk("t5_busy_end", 16'(busy_s[3]), 16'h0);

    // Asynchronous reset during the third data bit with two words queued
    baud_en = 1'b0;
    tick(1);
    push(0, 8'hAA);
    push(0, 8'hBB);
    push(0, 8'hCC);
    baud_en = 1'b1;
    wait_start(0, "t6");
    tick(64 * 3 + 20);
    chk("t6_pre_count", 16'(cnt_s[0]), 16'h2);
    chk("t6_pre_txd", 16'(txd_s[0]), 16'h0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_txd", 16'(txd_s[0]), 16'h1);
    chk("t6_rst_count", 16'(cnt_s[0]), 16'h0);
    chk("t6_rst_busy", 16'(busy_s[0]), 16'h0);
    chk("t6_rst_ready", 16'(rdy_s[0]), 16'h1);
    #5;
    tick(3);
    #3 reset = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (txd_s[0] == 1'b0) saw_low = 1'b1;
    end
    chk("t6_no_frame", 16'(saw_low), 16'h0);
    chk("t6_idle_busy", 16'(busy_s[0]), 16'h0);
    push(0, 8'h5A);
    wait_start(0, "t6n");
    check_frame(0, {1'b1, 8'h5A, 1'b0}, 10, "t6n");
    chk("t6n_busy_end", 16'(busy_s[0]), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
